// File: rtl/div_pkg.sv
// Shared types and helpers for the pipelined restoring divider.
package div_pkg;

    // Per-operation flags carried alongside the datapath.
    typedef struct packed {
        logic dz;      // divisor was zero
        logic ovf;     // most-negative / -1 in signed mode
        logic sign_q;  // quotient must be negated at the end
        logic sign_r;  // remainder must be negated at the end
    } div_flags_t;

    // Number of register stages for a given row grouping.
    function automatic int unsigned div_latency(input int unsigned a_width,
                                                input int unsigned stages_per_reg);
        return (a_width + stages_per_reg - 1) / stages_per_reg;
    endfunction

endpackage

// File: rtl/div_pipe_stage.sv
// One registered group of restoring-division rows. The last stage also applies the
// signed fixup and overflow/divide-by-zero overrides before its output register.
module div_pipe_stage
    import div_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned TAG_WIDTH = 4,
    parameter int unsigned ROWS      = 4,
    parameter bit          LAST      = 1'b0
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic [B_WIDTH-1:0]   i_rem,
    input  logic [A_WIDTH-1:0]   i_dvd,
    input  logic [A_WIDTH-1:0]   i_quo,
    input  logic [B_WIDTH-1:0]   i_dvs,
    input  div_flags_t           i_flags,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_valid,
    output logic [B_WIDTH-1:0]   o_rem,
    output logic [A_WIDTH-1:0]   o_dvd,
    output logic [A_WIDTH-1:0]   o_quo,
    output logic [B_WIDTH-1:0]   o_dvs,
    output div_flags_t           o_flags,
    output logic [TAG_WIDTH-1:0] o_tag
);

    localparam logic [A_WIDTH-1:0] A_MIN = {1'b1, {(A_WIDTH-1){1'b0}}};

    logic                 r_valid;
    logic [B_WIDTH-1:0]   r_rem;
    logic [A_WIDTH-1:0]   r_dvd;
    logic [A_WIDTH-1:0]   r_quo;
    logic [B_WIDTH-1:0]   r_dvs;
    div_flags_t           r_flags;
    logic [TAG_WIDTH-1:0] r_tag;

    logic [B_WIDTH-1:0]   w_rem;
    logic [A_WIDTH-1:0]   w_dvd;
    logic [A_WIDTH-1:0]   w_quo;
    logic [B_WIDTH-1:0]   w_rem_fix;
    logic [A_WIDTH-1:0]   w_quo_fix;

    // Restoring rows: shift in the next dividend bit, subtract the divisor when it fits.
    always_comb begin : rows
        logic [B_WIDTH:0] w_trial;
        logic [B_WIDTH:0] w_diff;
        w_trial = '0;
        w_diff  = '0;
        w_rem   = i_rem;
        w_dvd   = i_dvd;
        w_quo   = i_quo;
        for (int k = 0; k < int'(ROWS); k++) begin
            w_trial = {w_rem, w_dvd[A_WIDTH-1]};
            w_dvd   = {w_dvd[A_WIDTH-2:0], 1'b0};
            if (w_trial >= {1'b0, i_dvs}) begin
                w_diff = w_trial - {1'b0, i_dvs};
                w_rem  = w_diff[B_WIDTH-1:0];
                w_quo  = {w_quo[A_WIDTH-2:0], 1'b1};
            end else begin
                w_rem  = w_trial[B_WIDTH-1:0];
                w_quo  = {w_quo[A_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign restore and special-case overrides, only in the final stage.
    always_comb begin
        w_quo_fix = w_quo;
        w_rem_fix = w_rem;
        if (LAST) begin
            if (i_flags.ovf) begin
                w_quo_fix = A_MIN;
                w_rem_fix = '0;
            end else if (!i_flags.dz) begin
                // A zero divisor keeps the raw dividend bits as remainder, so no fixup there.
                if (i_flags.sign_q) begin
                    w_quo_fix = -w_quo;
                end
                if (i_flags.sign_r) begin
                    w_rem_fix = -w_rem;
                end
            end
        end
    end

    // Stage register; the whole pipeline advances or holds together on i_en.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_valid <= 1'b0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_flags <= '0;
            r_tag   <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_rem   <= w_rem_fix;
            r_dvd   <= w_dvd;
            r_quo   <= w_quo_fix;
            r_dvs   <= i_dvs;
            r_flags <= i_flags;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_rem   = r_rem;
    assign o_dvd   = r_dvd;
    assign o_quo   = r_quo;
    assign o_dvs   = r_dvs;
    assign o_flags = r_flags;
    assign o_tag   = r_tag;

endmodule

// File: rtl/pipelined_divider.sv
// Streaming integer divider: restoring row array cut into register stages, with a
// global-enable valid/ready handshake, optional signed mode and tag passthrough.
module pipelined_divider
    import div_pkg::*;
#(
    parameter int unsigned A_WIDTH        = 16,
    parameter int unsigned B_WIDTH        = 16,
    parameter int unsigned STAGES_PER_REG = 4,
    parameter int unsigned SIGNED         = 0,
    parameter int unsigned TAG_WIDTH      = 4
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_WIDTH-1:0]   out_q,
    output logic [B_WIDTH-1:0]   out_r,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_dz,
    output logic                 out_ovf
);

    localparam int unsigned        L         = div_latency(A_WIDTH, STAGES_PER_REG);
    localparam bit                 IS_SIGNED = (SIGNED != 0);
    localparam logic [A_WIDTH-1:0] A_MIN     = {1'b1, {(A_WIDTH-1){1'b0}}};
    localparam logic [B_WIDTH-1:0] B_ONES    = '1;

    logic                 w_en;
    logic                 w_dz;
    logic                 w_ovf;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [A_WIDTH-1:0]   w_a_mag;
    logic [B_WIDTH-1:0]   w_b_mag;
    div_flags_t           w_flags0;

    logic                 w_valid [0:L];
    logic [B_WIDTH-1:0]   w_rem   [0:L];
    logic [A_WIDTH-1:0]   w_dvd   [0:L];
    logic [A_WIDTH-1:0]   w_quo   [0:L];
    logic [B_WIDTH-1:0]   w_dvs   [0:L];
    div_flags_t           w_flags [0:L];
    logic [TAG_WIDTH-1:0] w_tag   [0:L];

    logic                 w_unused;

    // No bubble collapsing: everything moves only when the output slot can drain.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Operand preparation: magnitudes, recorded signs and special-case flags.
    always_comb begin
        w_dz     = (in_b == '0);
        w_a_neg  = IS_SIGNED && in_a[A_WIDTH-1];
        w_b_neg  = IS_SIGNED && in_b[B_WIDTH-1];
        w_ovf    = IS_SIGNED && (in_a == A_MIN) && (in_b == B_ONES);
        // Raw dividend on divide-by-zero so its low bits emerge unchanged as remainder.
        w_a_mag  = (w_a_neg && !w_dz) ? -in_a : in_a;
        w_b_mag  = w_b_neg ? -in_b : in_b;
        w_flags0        = '0;
        w_flags0.dz     = w_dz;
        w_flags0.ovf    = w_ovf;
        w_flags0.sign_q = w_a_neg ^ w_b_neg;
        w_flags0.sign_r = w_a_neg;
    end

    assign w_valid[0] = in_valid;
    assign w_rem[0]   = '0;
    assign w_dvd[0]   = w_a_mag;
    assign w_quo[0]   = '0;
    assign w_dvs[0]   = w_b_mag;
    assign w_flags[0] = w_flags0;
    assign w_tag[0]   = in_tag;

    for (genvar s = 0; s < int'(L); s++) begin : g_stage
        // The final stage absorbs any leftover rows.
        localparam int unsigned ROWS = ((s + 1) * STAGES_PER_REG <= A_WIDTH) ?
                                       STAGES_PER_REG : A_WIDTH - s * STAGES_PER_REG;

        div_pipe_stage #(
            .A_WIDTH   (A_WIDTH),
            .B_WIDTH   (B_WIDTH),
            .TAG_WIDTH (TAG_WIDTH),
            .ROWS      (ROWS),
            .LAST      (s == int'(L) - 1)
        ) u_stage (
            .clk     (clk),
            .nreset  (nreset),
            .i_en    (w_en),
            .i_valid (w_valid[s]),
            .i_rem   (w_rem[s]),
            .i_dvd   (w_dvd[s]),
            .i_quo   (w_quo[s]),
            .i_dvs   (w_dvs[s]),
            .i_flags (w_flags[s]),
            .i_tag   (w_tag[s]),
            .o_valid (w_valid[s+1]),
            .o_rem   (w_rem[s+1]),
            .o_dvd   (w_dvd[s+1]),
            .o_quo   (w_quo[s+1]),
            .o_dvs   (w_dvs[s+1]),
            .o_flags (w_flags[s+1]),
            .o_tag   (w_tag[s+1])
        );
    end

    assign out_valid = w_valid[L];
    assign out_q     = w_quo[L];
    assign out_r     = w_rem[L];
    assign out_tag   = w_tag[L];
    assign out_dz    = w_flags[L].dz;
    assign out_ovf   = w_flags[L].ovf;

    // Final-stage leftovers that have no consumer.
    assign w_unused = ^{w_dvd[L], w_dvs[L], w_flags[L].sign_q, w_flags[L].sign_r};

endmodule

// File: doc/pipelined_divider.md
Name: pipelined_divider

Overview:
- Streaming integer divider built from the team's restoring-division row array, cut into register stages by a parameter.
- Adds over the combinational array:
  - valid/ready handshake with backpressure
  - optional signed (two's complement) mode
  - divide-by-zero and signed-overflow flags
  - user tag passthrough
- Sits between producer and consumer datapath blocks that need one division per cycle at full throughput.

Parameters:
A_WIDTH, 16, dividend and quotient width (>= 2).
B_WIDTH, 16, divisor and remainder width (2..A_WIDTH).
STAGES_PER_REG, 4, division rows per pipeline register (1..A_WIDTH).
SIGNED, 0, 0 = unsigned operands; 1 = two's complement, truncation toward zero.
TAG_WIDTH, 4, sideband tag width carried alongside each operation (>= 1).

Ports:
clk  input  1  clock, rising edge.
nreset  input  1  asynchronous active-low reset.
in_valid  input  1  operands valid.
in_ready  output  1  divider accepts operands this cycle.
in_a  input  A_WIDTH  dividend.
in_b  input  B_WIDTH  divisor.
in_tag  input  TAG_WIDTH  user tag.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_q  output  A_WIDTH  quotient.
out_r  output  B_WIDTH  remainder.
out_tag  output  TAG_WIDTH  tag of this result.
out_dz  output  1  divisor was zero.
out_ovf  output  1  signed overflow (SIGNED=1 only, else 0).

Behaviour:
- Latency and throughput
  - L = ceil(A_WIDTH / STAGES_PER_REG) register stages. The last stage is the output register.
  - Result appears on out_* exactly L cycles after acceptance when out_ready is held high.
  - Throughput is one operation per cycle.
- Handshake
  - Transfer occurs when valid && ready on either side.
  - Global enable: en = !out_valid || out_ready. in_ready = en.
  - When en = 0, every stage, including its valid bits, holds. No bubble collapsing.
  - Outputs are stable while out_valid && !out_ready.
  - Results leave in acceptance order.
- Reset
  - Asynchronous.
  - All stage valid bits = 0, so out_valid = 0 and in_ready = 1 after reset.
  - out_q, out_r, out_tag, out_dz and out_ovf reset to 0.
  - Reset mid-operation discards all in-flight operations. Nothing emerges after release.
- Arithmetic
  - Unsigned:
    - Standard restoring division, one quotient bit per row, MSB first.
    - Rows 0..B_WIDTH-1 are B_WIDTH wide; the remaining rows are B_WIDTH+1 wide.
    - Partial remainder is B_WIDTH bits between rows.
  - Signed:
    - First stage converts both operands to magnitudes and records both signs.
    - The signs travel down the pipeline.
    - Last stage negates q if the signs differ, and negates r if the dividend is negative.
    - Results satisfy a = q*b + r with |r| < |b| and sign(r) = sign(a) or r = 0.
- Divide by zero (in_b = 0)
  - out_dz = 1, out_q = all ones, out_r = in_a[B_WIDTH-1:0]. No sign fixup is applied.
  - out_ovf = 0.
- Signed overflow (SIGNED=1, in_a = most-negative, in_b = -1)
  - out_q = most-negative A_WIDTH value, out_r = 0, out_ovf = 1.
- out_dz and out_ovf are 0 for every other result.
- in_tag is returned unmodified with its own result.
- STAGES_PER_REG not dividing A_WIDTH: the final stage holds the leftover rows.

Decomposition:
- Package div_pkg holds:
  - function div_latency(A_WIDTH, STAGES_PER_REG)
  - packed struct div_flags_t {dz, ovf, sign_q, sign_r}
- Sub-module div_pipe_stage:
  - One registered group of STAGES_PER_REG rows.
  - Ports: partial remainder, remaining dividend bits, quotient so far, divisor, flags, tag, valid, en.
  - Instantiated L times via generate.

Test Plan:
- Unsigned defaults: a=1000, b=7, out_ready=1 -> q=142, r=6, dz=0, result exactly 4 cycles after acceptance.
- SIGNED=1: a=-7 (0xFFF9), b=2 -> q=-3 (0xFFFD), r=-1 (0xFFFF). a=7, b=-2 -> q=-3, r=1.
- Divide by zero: a=0x1234, b=0, tag=5 -> q=0xFFFF, r=0x1234, dz=1, out_tag=5.
- SIGNED=1 overflow: a=0x8000, b=0xFFFF -> q=0x8000, r=0, ovf=1, dz=0.
- Backpressure with 8 back-to-back ops (tags 0..7): out_ready low for 3 cycles mid-stream -> in_ready low during the stall, out_* stable, all 8 results correct, in tag order, no duplicates.
- Reset mid-flight: 3 ops accepted, then nreset low for 1 cycle -> out_valid drops immediately, no result appears within 10 cycles after release, and a new op afterwards completes with latency L.
